// File: rtl/ifm_buf_loader.sv
// ifm_buf_loader
//   Fills one input-feature-map row buffer from external memory. A one-hot
//   load pulse selects the target buffer and the row. The block streams
//   N = q_width*q_channel consecutive words, starting at
//   q_base_addr + row*N, into buffer addresses 0..N-1. It then raises that
//   buffer's done flag.
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   q_width/q_channel         row geometry, sampled when a job is accepted
//   q_base_addr               IFM base word address
//   i_load_start/i_load_row   one-hot load pulse and the row to load
//   i_buf_release             per-buffer clear of the done flag
//   o_rd_req/o_rd_addr        memory read request (handshake with i_rd_gnt)
//   i_rd_valid/i_rd_data      in-order read responses
//   o_buf_we/o_buf_addr/o_buf_wdata   registered buffer write port
//   o_buf_done                per-buffer row-loaded flag
//   o_busy, o_err             job activity and sticky error flag
module ifm_buf_loader #(
  parameter int W_SIZE      = 12,
  parameter int W_CHANNEL   = 6,
  parameter int IFM_BUF_CNT = 4,
  parameter int W_IFM_BUF   = 2,
  parameter int W_ADDR      = 24,
  parameter int W_DATA      = 32,
  parameter int W_BUF_ADDR  = 10,
  parameter int MAX_OUT     = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [W_SIZE-1:0]      q_width,
  input  logic [W_CHANNEL-1:0]   q_channel,
  input  logic [W_ADDR-1:0]      q_base_addr,
  input  logic [IFM_BUF_CNT-1:0] i_load_start,
  input  logic [W_SIZE-1:0]      i_load_row,
  input  logic [IFM_BUF_CNT-1:0] i_buf_release,
  output logic                   o_rd_req,
  output logic [W_ADDR-1:0]      o_rd_addr,
  input  logic                   i_rd_gnt,
  input  logic                   i_rd_valid,
  input  logic [W_DATA-1:0]      i_rd_data,
  output logic [IFM_BUF_CNT-1:0] o_buf_we,
  output logic [W_BUF_ADDR-1:0]  o_buf_addr,
  output logic [W_DATA-1:0]      o_buf_wdata,
  output logic [IFM_BUF_CNT-1:0] o_buf_done,
  output logic                   o_busy,
  output logic                   o_err
);

  localparam int W_N   = W_SIZE + W_CHANNEL;
  localparam int W_PRD = W_SIZE + W_N;
  localparam int W_OUT = $clog2(MAX_OUT + 1);
  localparam logic [W_OUT-1:0] MAX_OUT_V = W_OUT'(MAX_OUT);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                 state;
  logic [W_IFM_BUF-1:0]   job_idx;
  logic [W_N-1:0]         job_n;
  logic [W_N-1:0]         iss_cnt;
  logic [W_N-1:0]         wr_cnt;
  logic [W_OUT-1:0]       outstanding;
  logic                   fin;
  logic                   pend_valid;
  logic [W_IFM_BUF-1:0]   pend_idx;
  logic [W_SIZE-1:0]      pend_row;

  logic                   grant;
  logic                   rsp;
  logic                   stray;
  logic [W_OUT-1:0]       out_next;
  logic                   pulse_one;
  logic                   pulse_multi;
  logic                   start_pend;
  logic                   start_new;
  logic                   accept;
  logic                   capture;
  logic                   drop;
  logic [W_IFM_BUF-1:0]   acc_idx;
  logic [W_SIZE-1:0]      acc_row;
  logic [W_N-1:0]         n_now;
  logic [W_ADDR-1:0]      acc_addr;
  logic                   pend_nx;
  logic                   run_nx;
  logic                   busy_nx;
  logic [IFM_BUF_CNT-1:0] done_nx;

  function automatic logic is_onehot(input logic [IFM_BUF_CNT-1:0] v);
    return (v != '0) && ((v & (v - IFM_BUF_CNT'(1))) == '0);
  endfunction

  function automatic logic [W_IFM_BUF-1:0] enc(input logic [IFM_BUF_CNT-1:0] v);
    logic [W_IFM_BUF-1:0] idx;
    idx = '0;
    for (int i = 0; i < IFM_BUF_CNT; i++)
      if (v[i]) idx = W_IFM_BUF'(i);
    return idx;
  endfunction

  function automatic logic [IFM_BUF_CNT-1:0] dec(input logic [W_IFM_BUF-1:0] idx);
    return IFM_BUF_CNT'(1) << idx;
  endfunction

  always_comb begin
    grant       = o_rd_req & i_rd_gnt;
    // Responses are only meaningful while something is outstanding; any
    // other i_rd_valid is stray and must not reach the buffer.
    rsp         = i_rd_valid & (outstanding != '0);
    stray       = i_rd_valid & (outstanding == '0);
    out_next    = outstanding + W_OUT'(grant) - W_OUT'(rsp);

    pulse_one   = is_onehot(i_load_start);
    pulse_multi = (i_load_start != '0) & ~pulse_one;

    // A held job always starts before a fresh pulse; the fresh pulse then
    // takes over the slot the held job just vacated.
    start_pend  = (state == IDLE) & pend_valid;
    start_new   = (state == IDLE) & ~pend_valid & pulse_one;
    accept      = start_pend | start_new;
    capture     = pulse_one & ~start_new & (~pend_valid | start_pend);
    drop        = pulse_one & ~start_new & pend_valid & ~start_pend;

    acc_idx     = start_pend ? pend_idx : enc(i_load_start);
    acc_row     = start_pend ? pend_row : i_load_row;
    n_now       = W_N'(q_width) * W_N'(q_channel);
    acc_addr    = q_base_addr + W_ADDR'(W_PRD'(acc_row) * W_PRD'(n_now));

    pend_nx     = capture | (pend_valid & ~start_pend);
    case (state)
      IDLE:    run_nx = accept & (n_now != '0);
      LOAD:    run_nx = 1'b1;
      default: run_nx = ~fin;
    endcase
    busy_nx     = run_nx | pend_nx;

    // Release clears, accept clears, completion sets; a zero-length job
    // completes on the accept itself. Completion only happens in DRAIN so
    // it never coincides with an accept.
    done_nx = o_buf_done & ~i_buf_release;
    if (accept) done_nx[acc_idx] = (n_now == '0);
    if (fin)    done_nx[job_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      job_idx     <= '0;
      job_n       <= '0;
      iss_cnt     <= '0;
      wr_cnt      <= '0;
      outstanding <= '0;
      fin         <= 1'b0;
      pend_valid  <= 1'b0;
      pend_idx    <= '0;
      pend_row    <= '0;
      o_rd_req    <= 1'b0;
      o_rd_addr   <= '0;
      o_buf_we    <= '0;
      o_buf_addr  <= '0;
      o_buf_wdata <= '0;
      o_buf_done  <= '0;
      o_busy      <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_buf_we    <= '0;
      o_busy      <= busy_nx;
      o_buf_done  <= done_nx;
      outstanding <= out_next;
      pend_valid  <= pend_nx;

      if (capture) begin
        pend_idx <= enc(i_load_start);
        pend_row <= i_load_row;
      end

      if (pulse_multi | drop | stray) o_err <= 1'b1;

      if (rsp) begin
        o_buf_we    <= dec(job_idx);
        o_buf_addr  <= W_BUF_ADDR'(wr_cnt);
        o_buf_wdata <= i_rd_data;
        wr_cnt      <= wr_cnt + W_N'(1);
        if (wr_cnt + W_N'(1) == job_n) fin <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (accept) begin
            job_idx   <= acc_idx;
            job_n     <= n_now;
            iss_cnt   <= '0;
            wr_cnt    <= '0;
            o_rd_addr <= acc_addr;
            if (n_now != '0) begin
              state    <= LOAD;
              o_rd_req <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (grant) begin
            iss_cnt <= iss_cnt + W_N'(1);
            if (iss_cnt + W_N'(1) == job_n) begin
              o_rd_req <= 1'b0;
              state    <= DRAIN;
            end else begin
              o_rd_addr <= o_rd_addr + W_ADDR'(1);
              o_rd_req  <= (out_next < MAX_OUT_V);
            end
          end else begin
            // Address is held; only the throttle can change the request.
            o_rd_req <= (out_next < MAX_OUT_V);
          end
        end
        DRAIN: begin
          if (fin) begin
            fin   <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_buf_loader.sv
// tb_ifm_buf_loader
//   Bench for ifm_buf_loader. A single process drives all inputs once per
//   cycle, emulates an in-order memory with configurable latency and grant
//   and valid behaviour, and logs every granted address and buffer write.
//   A reference model builds the expected address and write lists from
//   address = base + row*N + k.
module tb_ifm_buf_loader;
  localparam int W_SIZE      = 12;
  localparam int W_CHANNEL   = 6;
  localparam int IFM_BUF_CNT = 4;
  localparam int W_IFM_BUF   = 2;
  localparam int W_ADDR      = 24;
  localparam int W_DATA      = 32;
  localparam int W_BUF_ADDR  = 10;
  localparam int MAX_OUT     = 8;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [W_SIZE-1:0]      q_width;
  logic [W_CHANNEL-1:0]   q_channel;
  logic [W_ADDR-1:0]      q_base_addr;
  logic [IFM_BUF_CNT-1:0] i_load_start;
  logic [W_SIZE-1:0]      i_load_row;
  logic [IFM_BUF_CNT-1:0] i_buf_release;
  logic                   o_rd_req;
  logic [W_ADDR-1:0]      o_rd_addr;
  logic                   i_rd_gnt;
  logic                   i_rd_valid;
  logic [W_DATA-1:0]      i_rd_data;
  logic [IFM_BUF_CNT-1:0] o_buf_we;
  logic [W_BUF_ADDR-1:0]  o_buf_addr;
  logic [W_DATA-1:0]      o_buf_wdata;
  logic [IFM_BUF_CNT-1:0] o_buf_done;
  logic                   o_busy;
  logic                   o_err;

  always #5 clk = ~clk;

  ifm_buf_loader #(
    .W_SIZE(W_SIZE), .W_CHANNEL(W_CHANNEL), .IFM_BUF_CNT(IFM_BUF_CNT),
    .W_IFM_BUF(W_IFM_BUF), .W_ADDR(W_ADDR), .W_DATA(W_DATA),
    .W_BUF_ADDR(W_BUF_ADDR), .MAX_OUT(MAX_OUT)
  ) dut (
    .clk(clk), .rst(rst), .q_width(q_width), .q_channel(q_channel),
    .q_base_addr(q_base_addr), .i_load_start(i_load_start),
    .i_load_row(i_load_row), .i_buf_release(i_buf_release),
    .o_rd_req(o_rd_req), .o_rd_addr(o_rd_addr), .i_rd_gnt(i_rd_gnt),
    .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data), .o_buf_we(o_buf_we),
    .o_buf_addr(o_buf_addr), .o_buf_wdata(o_buf_wdata),
    .o_buf_done(o_buf_done), .o_busy(o_busy), .o_err(o_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int lat      = 2;
  bit gnt_rand = 1'b0;
  bit vld_rand = 1'b0;
  int vallow   = -1;
  int last_wr_cyc = 0;

  logic [23:0] rq_addr[$];
  int          rq_due[$];
  logic [23:0] gnt_log[$];
  logic [3:0]  wr_we[$];
  int          wr_k[$];
  logic [31:0] wr_data[$];
  logic [23:0] ex_addr[$];
  logic [3:0]  ex_we[$];
  int          ex_k[$];
  logic [31:0] ex_data[$];

  typedef struct {
    logic [11:0] width;
    logic [5:0]  chn;
    logic [23:0] base;
    logic [11:0] row;
    logic [3:0]  start;
    bit          rnd;
    logic [23:0] exp_a0;
    int          exp_n;
  } vec_t;
  vec_t tbl[7];

  function automatic logic [31:0] mem_word(input logic [23:0] a);
    return {8'h00, a} * 32'h0100_0193 + 32'h00C0_FFEE;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: record this cycle's grant, advance, log writes, drive next inputs.
  task automatic cycle();
    if (o_rd_req && i_rd_gnt) begin
      gnt_log.push_back(o_rd_addr);
      rq_addr.push_back(o_rd_addr);
      rq_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    i_load_start  = '0;
    i_buf_release = '0;
    if (o_buf_we != '0) begin
      wr_we.push_back(o_buf_we);
      wr_k.push_back(int'(o_buf_addr));
      wr_data.push_back(o_buf_wdata);
      last_wr_cyc = cyc;
    end
    i_rd_gnt   = gnt_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
    if (rq_addr.size() > 0 && rq_due[0] <= cyc && vallow != 0 &&
        (!vld_rand || $urandom_range(0, 2) != 0)) begin
      i_rd_valid = 1'b1;
      i_rd_data  = mem_word(rq_addr.pop_front());
      void'(rq_due.pop_front());
      if (vallow > 0) vallow--;
    end
  endtask

  task automatic flush();
    rq_addr.delete(); rq_due.delete(); gnt_log.delete();
    wr_we.delete(); wr_k.delete(); wr_data.delete();
    ex_addr.delete(); ex_we.delete(); ex_k.delete(); ex_data.delete();
  endtask

  task automatic do_reset();
    gnt_rand = 1'b0; vld_rand = 1'b0; lat = 2; vallow = -1;
    i_load_start = '0; i_buf_release = '0;
    rst = 1'b1;
    cycle();
    cycle();
    flush();
    i_rd_valid = 1'b0;
    i_rd_data  = '0;
    check("rst_rd", 64'({o_rd_req, o_rd_addr}), 64'(0));
    check("rst_buf", 64'({o_buf_we, o_buf_addr, o_buf_done, o_busy, o_err}), 64'(0));
    check("rst_wdata", 64'(o_buf_wdata), 64'(0));
    rst = 1'b0;
  endtask

  // Expected reads and writes for one job, straight from the address rule.
  task automatic model_job(input int id, input logic [23:0] base, input logic [11:0] row, input int n);
    logic [23:0] a;
    for (int k = 0; k < n; k++) begin
      a = base + 24'(int'(row) * n + k);
      ex_addr.push_back(a);
      ex_we.push_back(4'(1) << id);
      ex_k.push_back(k % 1024);
      ex_data.push_back(mem_word(a));
    end
  endtask

  task automatic check_logs(input string name);
    int bad_a;
    int bad_w;
    bad_a = 0;
    bad_w = 0;
    check({name, "_nrd"}, 64'(gnt_log.size()), 64'(ex_addr.size()));
    for (int i = 0; i < ex_addr.size() && i < gnt_log.size(); i++)
      if (gnt_log[i] !== ex_addr[i]) bad_a++;
    check({name, "_rdaddr_bad"}, 64'(bad_a), 64'(0));
    check({name, "_nwr"}, 64'(wr_we.size()), 64'(ex_we.size()));
    for (int i = 0; i < ex_we.size() && i < wr_we.size(); i++)
      if (wr_we[i] !== ex_we[i] || wr_k[i] != ex_k[i] || wr_data[i] !== ex_data[i]) bad_w++;
    check({name, "_wr_bad"}, 64'(bad_w), 64'(0));
    gnt_log.delete(); wr_we.delete(); wr_k.delete(); wr_data.delete();
    ex_addr.delete(); ex_we.delete(); ex_k.delete(); ex_data.delete();
  endtask

  task automatic run_job(input string name, input logic [3:0] start, input logic [11:0] row,
                         input int budget, output logic [23:0] a0_seen, output int nwr);
    int n;
    int id;
    int t;
    n  = int'(q_width) * int'(q_channel);
    id = 0;
    for (int b = 0; b < IFM_BUF_CNT; b++) if (start[b]) id = b;
    i_buf_release = start;
    cycle();
    check({name, "_rel"}, 64'(o_buf_done[id]), 64'(0));
    model_job(id, q_base_addr, row, n);
    i_load_start = start;
    i_load_row   = row;
    cycle();
    if (n != 0) begin
      check({name, "_req1"}, 64'(o_rd_req), 64'(1));
      check({name, "_busy1"}, 64'(o_busy), 64'(1));
    end
    t = 0;
    while (!o_buf_done[id] && t < budget) begin
      cycle();
      t++;
    end
    check({name, "_done"}, 64'(o_buf_done[id]), 64'(1));
    check({name, "_busy0"}, 64'(o_busy), 64'(0));
    if (n != 0) check({name, "_donelat"}, 64'(cyc - last_wr_cyc), 64'(1));
    a0_seen = (gnt_log.size() > 0) ? gnt_log[0] : 24'h0;
    nwr     = wr_we.size();
    check_logs(name);
  endtask

  initial begin
    logic [23:0] a0;
    int nwr;
    int t;

    tbl[0] = '{12'd4,  6'd2, 24'h000100, 12'd3,  4'b0010, 1'b0, 24'h000118, 8};
    tbl[1] = '{12'd3,  6'd3, 24'h002000, 12'd1,  4'b0001, 1'b1, 24'h002009, 9};
    tbl[2] = '{12'd1,  6'd1, 24'hFFFFFE, 12'd5,  4'b1000, 1'b1, 24'h000003, 1};
    tbl[3] = '{12'd5,  6'd4, 24'h000040, 12'd0,  4'b0100, 1'b1, 24'h000040, 20};
    tbl[4] = '{12'd0,  6'd3, 24'h000010, 12'd2,  4'b0010, 1'b0, 24'h000000, 0};
    tbl[5] = '{12'd16, 6'd2, 24'h000800, 12'd2,  4'b0001, 1'b1, 24'h000840, 32};
    tbl[6] = '{12'd7,  6'd1, 24'h123456, 12'd10, 4'b1000, 1'b0, 24'h12349C, 7};

    rst = 1'b1; q_width = '0; q_channel = '0; q_base_addr = '0;
    i_load_start = '0; i_load_row = '0; i_buf_release = '0;
    i_rd_gnt = 1'b1; i_rd_valid = 1'b0; i_rd_data = '0;
    do_reset();

    // Stray response with nothing outstanding.
    i_rd_valid = 1'b1;
    i_rd_data  = 32'hDEAD_BEEF;
    cycle();
    check("stray_we", 64'(o_buf_we), 64'(0));
    check("stray_err", 64'(o_err), 64'(1));
    cycle();
    check("stray_nwr", 64'(wr_we.size()), 64'(0));

    // Table-driven jobs.
    do_reset();
    for (int i = 0; i < 7; i++) begin
      q_width = tbl[i].width; q_channel = tbl[i].chn; q_base_addr = tbl[i].base;
      gnt_rand = tbl[i].rnd; vld_rand = tbl[i].rnd;
      lat = tbl[i].rnd ? int'($urandom_range(1, 4)) : 2;
      run_job($sformatf("tbl%0d", i), tbl[i].start, tbl[i].row, 400, a0, nwr);
      if (tbl[i].exp_n != 0) check($sformatf("tbl%0d_a0", i), 64'(a0), 64'(tbl[i].exp_a0));
      check($sformatf("tbl%0d_n", i), 64'(nwr), 64'(tbl[i].exp_n));
    end
    check("tbl_noerr", 64'(o_err), 64'(0));

    // Randomized jobs against the model.
    for (int r = 0; r < 6; r++) begin
      logic [3:0] st;
      q_width     = 12'($urandom_range(1, 6));
      q_channel   = 6'($urandom_range(0, 3));
      q_base_addr = 24'($urandom);
      st          = 4'(1) << $urandom_range(0, 3);
      gnt_rand = 1'b1; vld_rand = 1'b1; lat = int'($urandom_range(1, 5));
      run_job($sformatf("rnd%0d", r), st, 12'($urandom_range(0, 50)), 400, a0, nwr);
      check($sformatf("rnd%0d_n", r), 64'(nwr), 64'(int'(q_width) * int'(q_channel)));
    end
    check("rnd_noerr", 64'(o_err), 64'(0));

    // Outstanding-read throttle.
    do_reset();
    q_width = 12'd4; q_channel = 6'd4; q_base_addr = 24'h003000;
    vallow = 0;
    i_load_start = 4'b0001; i_load_row = 12'd0;
    cycle();
    repeat (20) cycle();
    check("hold_ngnt", 64'(gnt_log.size()), 64'(8));
    check("hold_req", 64'(o_rd_req), 64'(0));
    vallow = 1;
    repeat (6) cycle();
    check("hold_resume", 64'(gnt_log.size()), 64'(9));
    check("hold_req2", 64'(o_rd_req), 64'(0));
    vallow = -1;
    t = 0;
    while (!o_buf_done[0] && t < 200) begin cycle(); t++; end
    check("hold_done", 64'(o_buf_done[0]), 64'(1));
    model_job(0, 24'h003000, 12'd0, 16);
    check_logs("hold");

    // Pending job plus a dropped pulse.
    do_reset();
    q_width = 12'd4; q_channel = 6'd2; q_base_addr = 24'h000100;
    i_load_start = 4'b0001; i_load_row = 12'd0; cycle();
    i_load_start = 4'b0100; i_load_row = 12'd1; cycle();
    check("pend_err0", 64'(o_err), 64'(0));
    i_load_start = 4'b1000; i_load_row = 12'd2; cycle();
    check("pend_err", 64'(o_err), 64'(1));
    check("pend_busy", 64'(o_busy), 64'(1));
    t = 0;
    while (!o_buf_done[2] && t < 300) begin cycle(); t++; end
    repeat (3) cycle();
    check("pend_done", 64'(o_buf_done), 64'(4'b0101));
    check("pend_busy0", 64'(o_busy), 64'(0));
    model_job(0, 24'h000100, 12'd0, 8);
    model_job(2, 24'h000100, 12'd1, 8);
    check_logs("pend");

    // Multi-hot pulse.
    do_reset();
    q_width = 12'd2; q_channel = 6'd1; q_base_addr = 24'h000500;
    run_job("pre", 4'b0001, 12'd0, 100, a0, nwr);
    i_load_start = 4'b0011; i_load_row = 12'd1;
    cycle();
    repeat (5) cycle();
    check("multi_nrd", 64'(gnt_log.size()), 64'(0));
    check("multi_err", 64'(o_err), 64'(1));
    check("multi_done", 64'(o_buf_done), 64'(4'b0001));
    check("multi_busy", 64'(o_busy), 64'(0));

    // Release colliding with done set, then a plain release.
    do_reset();
    q_width = 12'd4; q_channel = 6'd1; q_base_addr = 24'h000700;
    i_load_start = 4'b0010; i_load_row = 12'd0;
    cycle();
    t = 0;
    while (wr_we.size() < 4 && t < 100) begin cycle(); t++; end
    i_buf_release = 4'b0010;
    cycle();
    check("relset_done", 64'(o_buf_done[1]), 64'(1));
    i_buf_release = 4'b0010;
    cycle();
    check("rel_done", 64'(o_buf_done[1]), 64'(0));

    // Reset in the middle of a load, then a fresh job.
    do_reset();
    q_width = 12'd8; q_channel = 6'd2; q_base_addr = 24'h000900;
    i_load_start = 4'b0100; i_load_row = 12'd1;
    cycle();
    repeat (4) cycle();
    check("mid_busy", 64'(o_busy), 64'(1));
    do_reset();
    repeat (3) cycle();
    check("mid_quiet", 64'(wr_we.size() + gnt_log.size()), 64'(0));
    run_job("post_rst", 4'b0100, 12'd1, 300, a0, nwr);
    check("post_rst_a0", 64'(a0), 64'(24'h000910));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifm_buf_loader.md
IFM_BUF_LOADER -- requirements
Module: ifm_buf_loader

Interface
REQ-001 SHALL have parameters: W_SIZE 12, row/col width; W_CHANNEL 6, tiled channel width; IFM_BUF_CNT 4, number of IFM row buffers; W_IFM_BUF 2, buffer index width; W_ADDR 24, memory word address width; W_DATA 32, word width; W_BUF_ADDR 10, buffer word address width; MAX_OUT 8, max outstanding reads.
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- q_width  in  W_SIZE  row width in pixels
- q_channel  in  W_CHANNEL  tiled input channel count
- q_base_addr  in  W_ADDR  IFM base word address
- i_load_start  in  IFM_BUF_CNT  one-hot load pulse from controller
- i_load_row  in  W_SIZE  row to load, valid with i_load_start
- i_buf_release  in  IFM_BUF_CNT  per-buffer clear of done
- o_rd_req  out  1  memory read request
- o_rd_addr  out  W_ADDR  read word address
- i_rd_gnt  in  1  request accepted when o_rd_req&&i_rd_gnt
- i_rd_valid  in  1  read data valid, in request order
- i_rd_data  in  W_DATA  read data
- o_buf_we  out  IFM_BUF_CNT  one-hot buffer write enable
- o_buf_addr  out  W_BUF_ADDR  buffer write address
- o_buf_wdata  out  W_DATA  buffer write data
- o_buf_done  out  IFM_BUF_CNT  per-buffer row-loaded flag (controller q_ifm_buf_done)
- o_busy  out  1  load in progress
- o_err  out  1  sticky error flag

Function
REQ-004 SHALL compute N = q_width*q_channel, width W_SIZE+W_CHANNEL, sampled at job accept; buffer layout k = chn*q_width + col, k in 0..N-1.
REQ-005 SHALL read memory word q_base_addr + i_load_row*N + k for k = 0..N-1 in increasing order; arithmetic truncated to W_ADDR.
REQ-006 SHALL implement FSM IDLE -> LOAD -> DRAIN -> IDLE: IDLE on job accept to LOAD; LOAD after N-th grant to DRAIN; DRAIN after N-th write to IDLE.
REQ-007 SHALL accept a job when i_load_start has exactly one bit set; a zero vector is ignored silently.
REQ-008 SHALL set o_err and ignore the pulse when i_load_start has more than one bit set.
REQ-009 SHALL hold one pending job (buffer id, row) when a valid pulse arrives while busy; pending starts the cycle after return to IDLE.
REQ-010 SHALL set o_err and drop the pulse when a valid pulse arrives while pending is full.
REQ-011 SHALL assert o_rd_req the cycle after accept and hold o_rd_addr stable until granted; next address the cycle after grant.
REQ-012 SHALL deassert o_rd_req when issued-minus-returned equals MAX_OUT; resume when a response returns.
REQ-013 SHALL register writes: o_buf_we[id], o_buf_addr=k, o_buf_wdata=i_rd_data one cycle after each i_rd_valid; o_buf_we zero otherwise.
REQ-014 SHALL clear o_buf_done[id] on accept and set it the cycle after the N-th write.
REQ-015 SHALL clear o_buf_done[b] on i_buf_release[b]; set wins over a simultaneous release of the same bit.
REQ-016 SHALL drive o_busy high from accept through the cycle o_buf_done sets, and while pending is valid.
REQ-017 SHALL set o_err on i_rd_valid with no outstanding request; the stray data is not written.
REQ-018 SHALL finish a job with N=0 in one cycle: no reads, done set the next cycle.

Reset
REQ-019 SHALL on rst: FSM IDLE, counters 0, pending empty, o_rd_req 0, o_rd_addr 0, o_buf_we 0, o_buf_addr 0, o_buf_wdata 0, o_buf_done 0, o_busy 0, o_err 0.
REQ-020 SHALL abandon an in-flight job on rst mid-operation, with no further writes or requests; rst wins over all inputs.

Verification
REQ-021 Width 4, channel 2, base 0x100, start 4'b0010, row 3, grant always, valid 2 cycles later -> addrs 0x118..0x11F; we[1] addrs 0..7; done[1] set 1 cycle after last write.
REQ-022 Grant always, rd_valid held low -> exactly 8 grants then o_rd_req low; one valid -> one more request.
REQ-023 Pulse 4'b0100 while busy, then 4'b1000 while pending is full -> buffer 2 loads after the first job; 4'b1000 dropped; o_err=1.
REQ-024 Start 4'b0011 -> no read, o_err=1, o_buf_done unchanged.
REQ-025 Release[1] in the same cycle done[1] sets -> done[1]=1; release next cycle -> 0.
REQ-026 rst asserted mid-LOAD, then fresh job -> all outputs at reset values; new job reads from k=0, done correct.
